uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; the downstream partner of the team's uart_tx.
- Oversamples the serial line with the same x16 clock and recovers 5–8 data bits, LSB first.
- Optionally checks one parity bit and one stop bit, configured identically to the transmitter.
- Delivers each received character as a one-cycle valid pulse with parity/frame error flags to the consuming logic.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the i_rx synchroniser (minimum 2).

Ports:
- i_clkx16  in  1  16x baud clock; the only clock.
- i_rst  in  1  reset.
- i_rx  in  1  serial line; idles high.
- i_exist_oddcheck  in  1  parity bit present; expected parity bit = XOR of received data bits.
- i_exist_evencheck  in  1  parity bit present; expected parity bit = inverted XOR of data bits. If both flags are set, oddcheck wins.
- i_exist_stop  in  1  one stop bit present.
- i_bitnum  in  4  data bits per frame, 5–8. Any other value is treated as 8.
- o_data  out  8  received character, right-justified, unused upper bits 0.
- o_data_valid  out  1  one-cycle pulse, character complete.
- o_parity_err  out  1  parity mismatch for the current o_data; valid with the pulse, held until the next pulse.
- o_frame_err  out  1  stop bit sampled 0; valid with the pulse, held until the next pulse.
- o_busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset and clocking:
  - One clock, i_clkx16.
  - Reset is asynchronous and active-high on i_rst.
  - Reset values: o_data=0, o_data_valid=0, o_parity_err=0, o_frame_err=0, o_busy=0.
  - Reset values of internal state: FSM=IDLE, synchroniser flops=1.
- Synchronisation: i_rx passes through SYNC_STAGES flops, giving rx_s; rx_d is rx_s delayed one cycle.
- Start detection:
  - Start edge = rx_d==1 & rx_s==0 while in IDLE.
  - A line held low never retriggers; a fresh 1→0 transition is required.
- Configuration latch: i_exist_*, i_bitnum are latched on the start-edge cycle and stay fixed for the frame.
- Bit timing:
  - 4-bit counter cnt clears on the start edge, then increments every cycle and wraps 15→0 at each bit boundary.
  - Decision cycle of a bit: cnt==8; the bit value is rx_s in that cycle.
  - cnt_bit counts data bits 1..bitnum.
- FSM states:
  - IDLE: on start edge → START.
  - START: at cnt==8, if rx_s==1 (false start) → IDLE, no output. At cnt==15 → RXDATA, cnt_bit=1.
  - RXDATA: at cnt==8, shift the bit into the data register MSB side, LSB-first assembly, aligned at completion.
    - At cnt==15 with cnt_bit<bitnum: cnt_bit+1.
    - Last data bit: with parity → CHECK at cnt==15. Else with stop → STOP at cnt==15. Else frame completes at that bit's decision cycle → IDLE.
  - CHECK: sample at cnt==8; parity_err = sampled ≠ expected.
    - With stop: → STOP at cnt==15.
    - Without stop: completes at the decision cycle → IDLE.
  - STOP: sample at cnt==8; frame_err = sampled==0. Completes at the decision cycle → IDLE.
- Completion:
  - Completion occurs at the final decision cycle, not at the end of the bit, so the next start edge is never missed.
  - o_data, o_parity_err and o_frame_err are registered on the completion edge.
  - o_data_valid is high for exactly the following cycle.
  - Latency: completion-edge register update plus 1 cycle after the final decision cycle.
- Break, or stop=0 on an all-zero character: o_data=0, o_frame_err=1, valid pulses. The FSM then waits in IDLE until the line has returned to 1 and fallen again.
- Flag rules:
  - Parity error and frame error may both be set.
  - Without parity, o_parity_err=0.
  - Without stop, o_frame_err=0.
- Reset mid-frame aborts the frame immediately: no valid pulse, outputs cleared.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: bit value at the decision cycle = 2-of-3 majority of rx_s at cnt==6,7,8, used for the start check, data, parity and stop. A single-cycle glitch at any sample point is rejected.
- Undefined: single sample of rx_s at cnt==8; no extra registers.

Test Plan:
1. Config 8 bits, no parity, stop; uart_tx sends 0xA5 → o_data=0xA5, o_data_valid high one cycle, both errors 0, o_busy low after.
2. Config 7 bits, oddcheck, stop; send 0x35 (parity bit 0) → o_data=0x35, parity_err=0. Resend with parity bit forced 1 → o_data=0x35, parity_err=1.
3. Config 8 bits, stop; drive 0x3C with stop bit forced 0 → o_data=0x3C, frame_err=1. Then a clean 0x3C frame → frame_err=0.
4. Low glitch of 4 cycles on idle line → START aborts at cnt==8, no valid pulse, o_busy returns 0, next frame 0x55 received correctly.
5. Config 5 bits, no parity, no stop; back-to-back uart_tx frames 0x1F then 0x0A → two valid pulses, o_data=0x1F then 0x0A, upper bits 0.
6. Assert i_rst during data bit 3 of 0xC3 → outputs 0 at once, no pulse; following 0x81 frame received correctly. With UART_RX_MAJORITY_EN, a 1-cycle inversion at cnt==8 of bit 0 still yields 0x81.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: x16-oversampling UART receiver, 5-8 data bits, optional parity/stop.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at cnt 6/7/8.
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clkx16,
    input  logic       i_rst,
    input  logic       i_rx,
    input  logic       i_exist_oddcheck,
    input  logic       i_exist_evencheck,
    input  logic       i_exist_stop,
    input  logic [3:0] i_bitnum,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RXDATA,
        CHECK,
        STOP
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic rx_s, rx_d;
    logic start_edge;

    logic       odd_q, even_q, stop_q;
    logic [3:0] bits_q;
    logic [3:0] bits_norm;
    logic       par_en;

    logic [3:0] cnt;
    logic [3:0] cnt_bit;
    logic       dec, bit_end, last;
    logic       bit_val;

    logic [7:0] shift_q, shift_nxt, data_aln;
    logic       exp_par;
    logic       par_bad_q, par_bad_nxt;
    logic       done;

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign start_edge = (state_q == IDLE) & rx_d & ~rx_s;
    assign dec        = (cnt == 4'd8);
    assign bit_end    = (cnt == 4'd15);
    assign last       = (cnt_bit == bits_q);
    assign par_en     = odd_q | even_q;
    assign bits_norm  = (i_bitnum >= 4'd5 && i_bitnum <= 4'd8) ? i_bitnum : 4'd8;

    // Line synchroniser; idles high so reset does not fake a start edge.
    always_ff @(posedge i_clkx16 or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '1;
            rx_d   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
            rx_d   <= rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic s6_q, s7_q;

    // Capture the two early samples for the majority vote at cnt==8.
    always_ff @(posedge i_clkx16 or posedge i_rst) begin
        if (i_rst) begin
            s6_q <= 1'b1;
            s7_q <= 1'b1;
        end else begin
            if (cnt == 4'd6) s6_q <= rx_s;
            if (cnt == 4'd7) s7_q <= rx_s;
        end
    end

    assign bit_val = (s6_q & s7_q) | (s6_q & rx_s) | (s7_q & rx_s);
`else
    assign bit_val = rx_s;
`endif

    // Frame configuration is frozen at the start edge.
    always_ff @(posedge i_clkx16 or posedge i_rst) begin
        if (i_rst) begin
            odd_q  <= 1'b0;
            even_q <= 1'b0;
            stop_q <= 1'b0;
            bits_q <= 4'd8;
        end else if (start_edge) begin
            odd_q  <= i_exist_oddcheck;
            even_q <= i_exist_evencheck;
            stop_q <= i_exist_stop;
            bits_q <= bits_norm;
        end
    end

    // Oversample counter: held at 0 in IDLE, free-runs within a frame.
    always_ff @(posedge i_clkx16 or posedge i_rst) begin
        if (i_rst) begin
            cnt <= 4'd0;
        end else if (state_q == IDLE) begin
            cnt <= 4'd0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    // Data bit counter, 1..bits_q while in RXDATA.
    always_ff @(posedge i_clkx16 or posedge i_rst) begin
        if (i_rst) begin
            cnt_bit <= 4'd0;
        end else if (state_q == START && bit_end) begin
            cnt_bit <= 4'd1;
        end else if (state_q == RXDATA && bit_end && !last) begin
            cnt_bit <= cnt_bit + 4'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clkx16 or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_edge) state_d = START;
            end
            START: begin
                if (dec && bit_val) state_d = IDLE;
                else if (bit_end)   state_d = RXDATA;
            end
            RXDATA: begin
                if (last) begin
                    if (dec && !par_en && !stop_q) state_d = IDLE;
                    else if (bit_end && par_en)    state_d = CHECK;
                    else if (bit_end && stop_q)    state_d = STOP;
                end
            end
            CHECK: begin
                if (dec && !stop_q) state_d = IDLE;
                else if (bit_end)   state_d = STOP;
            end
            STOP: begin
                if (dec) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy flag and completion strobe at the final decision.
    always_comb begin
        o_busy = (state_q != IDLE);
        done   = 1'b0;
        unique case (state_q)
            RXDATA:  done = dec & last & ~par_en & ~stop_q;
            CHECK:   done = dec & ~stop_q;
            STOP:    done = dec;
            default: done = 1'b0;
        endcase
    end

    // Look-ahead values so completion on a data/parity bit sees that bit.
    always_comb begin
        shift_nxt = shift_q;
        if (state_q == RXDATA && dec) shift_nxt = {bit_val, shift_q[7:1]};
        data_aln = shift_nxt >> (4'd8 - bits_q);
        exp_par  = odd_q ? ^data_aln : ~^data_aln;
        par_bad_nxt = par_bad_q;
        if (state_q == CHECK && dec) par_bad_nxt = (bit_val != exp_par);
    end

    // Shift register and parity mismatch holder for the current frame.
    always_ff @(posedge i_clkx16 or posedge i_rst) begin
        if (i_rst) begin
            shift_q   <= 8'd0;
            par_bad_q <= 1'b0;
        end else if (start_edge) begin
            par_bad_q <= 1'b0;
        end else begin
            shift_q   <= shift_nxt;
            par_bad_q <= par_bad_nxt;
        end
    end

    // Result registers: loaded on completion, valid pulses the next cycle.
    always_ff @(posedge i_clkx16 or posedge i_rst) begin
        if (i_rst) begin
            o_data       <= 8'd0;
            o_data_valid <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_data_valid <= done;
            if (done) begin
                o_data       <= data_aln;
                o_parity_err <= par_en & par_bad_nxt;
                o_frame_err  <= (state_q == STOP) & ~bit_val;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed UART frames against a frame-level model.
// Expected characters are queued per frame and matched on each valid pulse.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       odd, even, stp;
    logic [3:0] bn;
    logic [7:0] data;
    logic       dv, pe, fe, busy;

    always #5 clk = ~clk;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .i_clkx16          (clk),
        .i_rst             (rst),
        .i_rx              (rx),
        .i_exist_oddcheck  (odd),
        .i_exist_evencheck (even),
        .i_exist_stop      (stp),
        .i_bitnum          (bn),
        .o_data            (data),
        .o_data_valid      (dv),
        .o_parity_err      (pe),
        .o_frame_err       (fe),
        .o_busy            (busy)
    );

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic prev_v = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Match every valid pulse against the oldest outstanding frame.
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v) check("valid_width", dv, 0);
            if (dv && !prev_v) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", dv, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", data, e.d);
                    check("parity_err", pe, e.pe);
                    check("frame_err", fe, e.fe);
                end
            end
            prev_v = dv;
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v, input int g);
        for (int c = 0; c < 16; c++) begin
            rx = (c == g) ? ~v : v;
            @(negedge clk);
        end
    endtask

    // Send one frame on the line; the model queues what must come out.
    task automatic send_frame(input logic [7:0] d, input logic [3:0] nbits,
                              input logic po, input logic pv,
                              input logic s, input logic flip,
                              input logic stop_val, input int gbit);
        int         nb;
        logic [7:0] dd;
        logic       want_p, sent_p;
        exp_t       x;
        odd  = po;
        even = pv;
        stp  = s;
        bn   = nbits;
        nb   = (nbits >= 5 && nbits <= 8) ? int'(nbits) : 8;
        dd   = d & 8'((1 << nb) - 1);
        want_p = 1'b0;
        for (int i = 0; i < nb; i++) want_p = want_p ^ dd[i];
        if (!po) want_p = ~want_p;
        sent_p = want_p ^ flip;
        x.d  = dd;
        x.pe = (po | pv) ? (sent_p != want_p) : 1'b0;
        x.fe = s ? (stop_val == 1'b0) : 1'b0;
        exp_q.push_back(x);
        drive_bit(1'b0, -1);
        for (int i = 0; i < nb; i++) drive_bit(dd[i], (i == gbit) ? 9 : -1);
        if (po | pv) drive_bit(sent_p, -1);
        if (s) drive_bit(stop_val, -1);
    endtask

    logic [3:0] bn_tab [8];

    initial begin
        bn_tab = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd0, 4'd4, 4'd9, 4'd15};
        rst  = 1'b1;
        rx   = 1'b1;
        odd  = 1'b0;
        even = 1'b0;
        stp  = 1'b1;
        bn   = 4'd8;
        repeat (3) @(negedge clk);
        check("rst_data", data, 0);
        check("rst_valid", dv, 0);
        check("rst_perr", pe, 0);
        check("rst_ferr", fe, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        idle(20);

        // 8N1 basic character
        send_frame(8'hA5, 4'd8, 0, 0, 1, 0, 1, -1);
        idle(8);
        check("busy_after", busy, 0);
        idle(16);

        // 7 bits odd check, clean then corrupted parity
        send_frame(8'h35, 4'd7, 1, 0, 1, 0, 1, -1);
        idle(20);
        send_frame(8'h35, 4'd7, 1, 0, 1, 1, 1, -1);
        idle(20);

        // stop bit forced low, clean frame, then a break
        send_frame(8'h3C, 4'd8, 0, 0, 1, 0, 0, -1);
        idle(20);
        send_frame(8'h3C, 4'd8, 0, 0, 1, 0, 1, -1);
        idle(20);
        send_frame(8'h00, 4'd8, 0, 0, 1, 0, 0, -1);
        idle(24);

        // short low glitch must be rejected as a false start
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch_busy", busy, 1);
        idle(40);
        check("glitch_idle", busy, 0);
        send_frame(8'h55, 4'd8, 0, 0, 1, 0, 1, -1);
        idle(20);

        // 5 bits, no parity, no stop, back-to-back
        send_frame(8'h1F, 4'd5, 0, 0, 0, 0, 1, -1);
        send_frame(8'h0A, 4'd5, 0, 0, 0, 0, 1, -1);
        idle(24);

        // reset in the middle of data bit 3
        odd  = 1'b0;
        even = 1'b0;
        stp  = 1'b1;
        bn   = 4'd8;
        drive_bit(1'b0, -1);
        drive_bit(1'b1, -1);
        drive_bit(1'b1, -1);
        drive_bit(1'b0, -1);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_data", data, 0);
        check("abort_valid", dv, 0);
        check("abort_perr", pe, 0);
        check("abort_ferr", fe, 0);
        check("abort_busy", busy, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(32);
`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h81, 4'd8, 0, 0, 1, 0, 1, 0);
`else
        send_frame(8'h81, 4'd8, 0, 0, 1, 0, 1, -1);
`endif
        idle(24);

        // randomized frames over all configurations
        for (int k = 0; k < 30; k++) begin
            send_frame(8'($urandom), bn_tab[$urandom_range(0, 7)],
                       1'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) != 0), -1);
            idle(16 + $urandom_range(0, 16));
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("pending_frames", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
